bus_sequence_controller: RTL and testbench
==========================================

BUS_SEQUENCE_CONTROLLER -- requirements
Module: bus_sequence_controller

Interface
REQ-001 Parameter ADDR_W, default 12, sets the address and data width the datapath is sized to.
REQ-002 Parameter OP_W, default 3, sets the opcode width.
REQ-003 Port clk, input, 1, the single clock; every register updates on the rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port run, input, 1, allows a new instruction fetch to start from T0.
REQ-006 Port ir_opcode, input, OP_W, the IR opcode field; valid from T2 onward.
REQ-007 Port ir_i, input, 1, the IR indirect bit.
REQ-008 Port ir_hlt, input, 1, the IR bit 0, qualifying HLT when opcode is 7.
REQ-009 Port dr_zero, input, 1, high when DR equals 0 after increment.
REQ-010 Port bus_sel, output, 3, the common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM.
REQ-011 Ports ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_rd and mem_wr are 1-bit outputs; each is a register strobe or memory strobe.
REQ-012 Port alu_op, output, 2, selects the AC operation: 0 AND, 1 ADD, 2 LOAD DR.
REQ-013 Port rr_exec, output, 1, a one-cycle register-reference execute pulse.
REQ-014 Port instr_done, output, 1, a one-cycle pulse in the final T-state of every instruction.
REQ-015 Port halted, output, 1, high once HLT has executed.
REQ-016 Port t_state, output, 3, the current sequence-counter value T0 to T6.

Function
REQ-017 Outputs shall be combinational from t_state and the latched opcode and I bit; outputs not listed for a T-state are 0.
REQ-018 T0 with run=1 and halted=0: bus_sel=2, ld_ar. With run=0 or halted=1, the block stays in T0 and all strobes are 0.
REQ-019 T1: bus_sel=7, mem_rd, ld_ir, inc_pc.
REQ-020 T2: bus_sel=5, ld_ar; ir_opcode, ir_i and ir_hlt are latched at the end of this cycle.
REQ-021 T3 with opcode 7: rr_exec and instr_done are asserted, then the block returns to T0; if ir_hlt=1, halted is set at that edge.
REQ-022 T3 with opcode other than 7: the indirect cycle (see REQ-030), then T4.
REQ-023 AND, ADD and LDA (opcodes 0, 1, 2):
- T4: bus_sel=7, mem_rd, ld_dr.
- T5: ld_ac with alu_op 0, 1 or 2 respectively; instr_done; then T0.
REQ-024 STA (opcode 3), T4: bus_sel=4, mem_wr, instr_done; then T0.
REQ-025 BUN (opcode 4), T4: bus_sel=1, ld_pc, instr_done; then T0.
REQ-026 BSA (opcode 5):
- T4: bus_sel=2, mem_wr, inc_ar.
- T5: bus_sel=1, ld_pc, instr_done; then T0.
REQ-027 ISZ (opcode 6):
- T4: bus_sel=7, mem_rd, ld_dr.
- T5: inc_dr.
- T6: bus_sel=3, mem_wr, instr_done, and inc_pc if dr_zero=1; then T0.
REQ-028 Latency: each instruction takes 4 to 7 cycles from T0 to T0; the sequence counter never exceeds T6.
REQ-029 ir_opcode and ir_i changes after T2 shall not affect the instruction in flight; run is sampled only in T0.

Configuration
REQ-030 With INDIRECT_EN defined, T3 for a memory-reference instruction with I=1 drives bus_sel=7, mem_rd and ld_ar; with I=0, T3 drives no strobes.
REQ-031 Without INDIRECT_EN, I is ignored and T3 drives no strobes for any memory-reference instruction; cycle counts are unchanged.

Reset
REQ-032 While reset=0: t_state=T0, halted=0, the latched opcode and I are 0, and every strobe, rr_exec and instr_done are 0, asynchronously.
REQ-033 Reset asserted mid-instruction abandons the instruction; the first cycle after release is T0.

Structure
REQ-034 A shared package holds:
- the bus_sel source encodings;
- the opcode constants AND..ISZ and RR;
- the alu_op encodings;
- the T-state width and constants.
REQ-035 Sub-module seq_counter holds the 3-bit counter with clear, hold and increment inputs; it is reset by reset.

Verification
REQ-036 Reset, then run=1 with ir_opcode=1, ir_i=0: T0..T5 visited; T5 gives ld_ac, alu_op=1, instr_done; then back to T0.
REQ-037 With INDIRECT_EN, ir_opcode=0 and ir_i=1: T3 gives bus_sel=7, mem_rd, ld_ar; without INDIRECT_EN, T3 gives all strobes 0.
REQ-038 ISZ with dr_zero=1 at T6: mem_wr, inc_pc and instr_done together; repeat with dr_zero=0: inc_pc stays 0.
REQ-039 ir_opcode=7 and ir_hlt=1: rr_exec pulses at T3, then halted=1; a later run=1 leaves t_state=T0 with no strobes.
REQ-040 Drop reset to 0 during BSA T4: all strobes go to 0 immediately; after release, t_state=T0.
REQ-041 run=0 for 5 cycles in T0: t_state holds T0 and ld_ar stays 0.

Source files
------------

// File: rtl/bus_sequence_controller_pkg.sv
// bus_sequence_controller_pkg: shared encodings for the bus sequence controller
//   bus_sel_e  : common-bus source select codes
//   OP_*       : memory-reference opcodes and the register-reference opcode
//   alu_op_e   : accumulator operation select
//   t_state_e  : sequence-counter T-states (T_W bits)
package bus_sequence_controller_pkg;
   localparam int T_W = 3;
   typedef enum logic [T_W-1:0] {T0, T1, T2, T3, T4, T5, T6} t_state_e;
   typedef enum logic [2:0] {
      BUS_NONE = 3'd0,
      BUS_AR   = 3'd1,
      BUS_PC   = 3'd2,
      BUS_DR   = 3'd3,
      BUS_AC   = 3'd4,
      BUS_IR   = 3'd5,
      BUS_MEM  = 3'd7
   } bus_sel_e;
   typedef enum logic [1:0] {ALU_AND = 2'd0, ALU_ADD = 2'd1, ALU_LDDR = 2'd2} alu_op_e;
   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_RR  = 3'd7;
endpackage

// File: rtl/bus_sequence_controller_seq_counter.sv
// seq_counter: T-state sequence counter with clear, hold and increment
//   clk, reset (async active-low), i_clr (to T0, highest priority),
//   i_hold (freeze), i_inc (advance), o_cnt (current T-state)
module seq_counter
   import bus_sequence_controller_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           i_clr,
   input  logic           i_hold,
   input  logic           i_inc,
   output logic [T_W-1:0] o_cnt
);
   logic [T_W-1:0] r_cnt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (!i_hold && i_inc) r_cnt <= r_cnt + T_W'(1);
   assign o_cnt = r_cnt;
endmodule

// File: rtl/bus_sequence_controller.sv
// bus_sequence_controller: T-state control sequencer for a basic accumulator CPU
//   in : clk, reset (async active-low), run, ir_opcode, ir_i, ir_hlt, dr_zero
//   out: bus_sel, register/memory strobes, alu_op, rr_exec, instr_done,
//        halted, t_state
//   INDIRECT_EN: when defined, T3 of a memory-reference instruction with I=1
//   performs the indirect address fetch; otherwise T3 is always idle.
module bus_sequence_controller
   import bus_sequence_controller_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int OP_W   = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic [OP_W-1:0] ir_opcode,
   input  logic            ir_i,
   input  logic            ir_hlt,
   input  logic            dr_zero,
   output logic [2:0]      bus_sel,
   output logic            ld_ar,
   output logic            inc_ar,
   output logic            ld_pc,
   output logic            inc_pc,
   output logic            ld_dr,
   output logic            inc_dr,
   output logic            ld_ac,
   output logic            ld_ir,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic [1:0]      alu_op,
   output logic            rr_exec,
   output logic            instr_done,
   output logic            halted,
   output logic [2:0]      t_state
);
   // The sequencer carries no datapath; ADDR_W only documents the sizing.
   localparam int unused_addr_w = ADDR_W;
   logic [T_W-1:0]  w_cnt;
   t_state_e        w_t;
   logic [OP_W-1:0] r_op;
   logic            r_i, r_hlt, r_halted;
   logic            w_go, w_hold, w_inc, w_ind, w_mref;
   logic            w_and, w_add, w_lda, w_sta, w_bun, w_bsa, w_isz, w_rr;
   // Gating with reset keeps T0 strobes low while reset is held.
   assign w_go   = reset & run & ~r_halted;
   assign w_hold = (w_t == T0) & ~w_go;
   assign w_inc  = ~instr_done & ~w_hold;
   assign w_and  = r_op == OP_W'(OP_AND);
   assign w_add  = r_op == OP_W'(OP_ADD);
   assign w_lda  = r_op == OP_W'(OP_LDA);
   assign w_sta  = r_op == OP_W'(OP_STA);
   assign w_bun  = r_op == OP_W'(OP_BUN);
   assign w_bsa  = r_op == OP_W'(OP_BSA);
   assign w_isz  = r_op == OP_W'(OP_ISZ);
   assign w_rr   = r_op == OP_W'(OP_RR);
   assign w_mref = w_and | w_add | w_lda | w_sta | w_bun | w_bsa | w_isz;
`ifdef INDIRECT_EN
   assign w_ind = w_mref & r_i;
`else
   logic w_unused_ind;
   assign w_ind        = 1'b0;
   assign w_unused_ind = r_i & w_mref;
`endif
   seq_counter u_seq (
      .clk   (clk),
      .reset (reset),
      .i_clr (instr_done),
      .i_hold(w_hold),
      .i_inc (w_inc),
      .o_cnt (w_cnt)
   );
   assign w_t     = t_state_e'(w_cnt);
   assign t_state = w_cnt;
   assign halted  = r_halted;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_op     <= '0;
         r_i      <= 1'b0;
         r_hlt    <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         if (w_t == T2) begin
            r_op  <= ir_opcode;
            r_i   <= ir_i;
            r_hlt <= ir_hlt;
         end
         if (w_t == T3 && w_rr && r_hlt) r_halted <= 1'b1;
      end
   always_comb begin
      bus_sel    = BUS_NONE;
      ld_ar      = 1'b0;
      inc_ar     = 1'b0;
      ld_pc      = 1'b0;
      inc_pc     = 1'b0;
      ld_dr      = 1'b0;
      inc_dr     = 1'b0;
      ld_ac      = 1'b0;
      ld_ir      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      alu_op     = ALU_AND;
      rr_exec    = 1'b0;
      instr_done = 1'b0;
      case (w_t)
         T0: if (w_go) begin
            bus_sel = BUS_PC;
            ld_ar   = 1'b1;
         end
         T1: begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ld_ir   = 1'b1;
            inc_pc  = 1'b1;
         end
         T2: begin
            bus_sel = BUS_IR;
            ld_ar   = 1'b1;
         end
         T3: if (w_rr) begin
            rr_exec    = 1'b1;
            instr_done = 1'b1;
         end else if (w_ind) begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ld_ar   = 1'b1;
         end
         T4: if (w_and || w_add || w_lda || w_isz) begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ld_dr   = 1'b1;
         end else if (w_sta) begin
            bus_sel    = BUS_AC;
            mem_wr     = 1'b1;
            instr_done = 1'b1;
         end else if (w_bun) begin
            bus_sel    = BUS_AR;
            ld_pc      = 1'b1;
            instr_done = 1'b1;
         end else if (w_bsa) begin
            bus_sel = BUS_PC;
            mem_wr  = 1'b1;
            inc_ar  = 1'b1;
         end else instr_done = 1'b1;
         T5: if (w_and || w_add || w_lda) begin
            ld_ac      = 1'b1;
            alu_op     = w_add ? ALU_ADD : w_lda ? ALU_LDDR : ALU_AND;
            instr_done = 1'b1;
         end else if (w_bsa) begin
            bus_sel    = BUS_AR;
            ld_pc      = 1'b1;
            instr_done = 1'b1;
         end else if (w_isz) inc_dr = 1'b1;
         else instr_done = 1'b1;
         T6: begin
            bus_sel    = BUS_DR;
            mem_wr     = 1'b1;
            inc_pc     = dr_zero;
            instr_done = 1'b1;
         end
         default: instr_done = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_bus_sequence_controller.sv
// tb_bus_sequence_controller: scoreboard bench with directed per-cycle vectors
module tb_bus_sequence_controller;
   logic       clk = 1'b0, reset = 1'b0, run = 1'b0, ir_i = 1'b0, ir_hlt = 1'b0, dr_zero = 1'b0;
   logic [2:0] ir_opcode = 3'd0;
   logic [2:0] bus_sel, t_state;
   logic [1:0] alu_op;
   logic       ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_rd, mem_wr;
   logic       rr_exec, instr_done, halted;
   localparam logic [9:0] LD_AR = 10'h200, INC_AR = 10'h100, LD_PC = 10'h080, INC_PC = 10'h040;
   localparam logic [9:0] LD_DR = 10'h020, INC_DR = 10'h010, LD_AC = 10'h008, LD_IR = 10'h004;
   localparam logic [9:0] RD = 10'h002, WR = 10'h001, NO = 10'h000;
`ifdef INDIRECT_EN
   localparam bit IND = 1'b1;
`else
   localparam bit IND = 1'b0;
`endif
   bus_sequence_controller dut (
      .clk(clk), .reset(reset), .run(run), .ir_opcode(ir_opcode), .ir_i(ir_i),
      .ir_hlt(ir_hlt), .dr_zero(dr_zero), .bus_sel(bus_sel), .ld_ar(ld_ar),
      .inc_ar(inc_ar), .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_dr(ld_dr), .inc_dr(inc_dr),
      .ld_ac(ld_ac), .ld_ir(ld_ir), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op),
      .rr_exec(rr_exec), .instr_done(instr_done), .halted(halted), .t_state(t_state)
   );
   always #5 clk = ~clk;
   typedef struct {string name; logic [20:0] v;} exp_t;
   exp_t       q[$];
   int         n_cmp = 0, n_err = 0;
   event       smp;
   logic [2:0] g_op = 3'd0;
   logic       g_i = 1'b0, g_hlt = 1'b0;
   wire [20:0] act = {t_state, bus_sel, ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr,
                      ld_ac, ld_ir, mem_rd, mem_wr, alu_op, rr_exec, instr_done, halted};
   function automatic logic [20:0] mk(input logic [2:0] t, input logic [2:0] b, input logic [9:0] s,
                                      input logic [1:0] a = 2'd0, input logic rr = 1'b0,
                                      input logic d = 1'b0, input logic h = 1'b0);
      return {t, b, s, a, rr, d, h};
   endfunction
   task automatic push(input string n, input logic [20:0] v);
      exp_t e;
      e.name = n;
      e.v    = v;
      q.push_back(e);
   endtask
   task automatic step(input string n, input logic r, input logic drz, input logic [20:0] v);
      @(posedge clk);
      #1;
      run       = r;
      dr_zero   = drz;
      ir_opcode = g_op;
      ir_i      = g_i;
      ir_hlt    = g_hlt;
      push(n, v);
   endtask
   // After T2 the IR fields are scrambled so only the latched copy can be used.
   task automatic fetch(input logic [2:0] op, input logic i, input logic h);
      g_op  = op;
      g_i   = i;
      g_hlt = h;
      step("fetch_t0", 1'b1, 1'b0, mk(3'd0, 3'd2, LD_AR));
      step("fetch_t1", 1'b0, 1'b0, mk(3'd1, 3'd7, RD | LD_IR | INC_PC));
      step("fetch_t2", 1'b0, 1'b0, mk(3'd2, 3'd5, LD_AR));
      g_op  = op ^ 3'b011;
      g_i   = ~i;
      g_hlt = ~h;
   endtask
   initial forever begin
      @(negedge clk or smp);
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         if (act !== e.v) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t,bus,strobes,alu,rr,done,halt)", e.name, act, e.v);
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      step("reset_run0", 1'b0, 1'b0, mk(3'd0, 3'd0, NO));
      step("reset_run1", 1'b1, 1'b0, mk(3'd0, 3'd0, NO));
      @(posedge clk);
      #1;
      reset = 1'b1;
      run   = 1'b0;
      push("after_release", mk(3'd0, 3'd0, NO));
      for (int k = 0; k < 5; k++) step("idle_run0", 1'b0, 1'b0, mk(3'd0, 3'd0, NO));
      fetch(3'd1, 1'b0, 1'b0);
      step("add_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO));
      step("add_t4", 1'b0, 1'b0, mk(3'd4, 3'd7, RD | LD_DR));
      step("add_t5", 1'b0, 1'b0, mk(3'd5, 3'd0, LD_AC, 2'd1, 1'b0, 1'b1));
      step("add_back_t0", 1'b0, 1'b0, mk(3'd0, 3'd0, NO));
      fetch(3'd0, 1'b1, 1'b0);
      step("and_ind_t3", 1'b0, 1'b0, IND ? mk(3'd3, 3'd7, RD | LD_AR) : mk(3'd3, 3'd0, NO));
      step("and_t4", 1'b0, 1'b0, mk(3'd4, 3'd7, RD | LD_DR));
      step("and_t5", 1'b0, 1'b0, mk(3'd5, 3'd0, LD_AC, 2'd0, 1'b0, 1'b1));
      fetch(3'd2, 1'b0, 1'b0);
      step("lda_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO));
      step("lda_t4", 1'b0, 1'b0, mk(3'd4, 3'd7, RD | LD_DR));
      step("lda_t5", 1'b0, 1'b0, mk(3'd5, 3'd0, LD_AC, 2'd2, 1'b0, 1'b1));
      fetch(3'd3, 1'b0, 1'b0);
      step("sta_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO));
      step("sta_t4", 1'b0, 1'b0, mk(3'd4, 3'd4, WR, 2'd0, 1'b0, 1'b1));
      fetch(3'd4, 1'b0, 1'b0);
      step("bun_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO));
      step("bun_t4", 1'b0, 1'b0, mk(3'd4, 3'd1, LD_PC, 2'd0, 1'b0, 1'b1));
      fetch(3'd5, 1'b0, 1'b0);
      step("bsa_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO));
      step("bsa_t4", 1'b0, 1'b0, mk(3'd4, 3'd2, WR | INC_AR));
      step("bsa_t5", 1'b0, 1'b0, mk(3'd5, 3'd1, LD_PC, 2'd0, 1'b0, 1'b1));
      fetch(3'd6, 1'b0, 1'b0);
      step("isz1_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO));
      step("isz1_t4", 1'b0, 1'b0, mk(3'd4, 3'd7, RD | LD_DR));
      step("isz1_t5", 1'b0, 1'b0, mk(3'd5, 3'd0, INC_DR));
      step("isz1_t6", 1'b0, 1'b1, mk(3'd6, 3'd3, WR | INC_PC, 2'd0, 1'b0, 1'b1));
      fetch(3'd6, 1'b0, 1'b0);
      step("isz0_t3", 1'b0, 1'b1, mk(3'd3, 3'd0, NO));
      step("isz0_t4", 1'b0, 1'b1, mk(3'd4, 3'd7, RD | LD_DR));
      step("isz0_t5", 1'b0, 1'b1, mk(3'd5, 3'd0, INC_DR));
      step("isz0_t6", 1'b0, 1'b0, mk(3'd6, 3'd3, WR, 2'd0, 1'b0, 1'b1));
      fetch(3'd7, 1'b0, 1'b0);
      step("rr_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO, 2'd0, 1'b1, 1'b1));
      fetch(3'd5, 1'b0, 1'b0);
      step("bsa_r_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO));
      step("bsa_r_t4", 1'b0, 1'b0, mk(3'd4, 3'd2, WR | INC_AR));
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      push("bsa_reset_async", mk(3'd0, 3'd0, NO));
      ->smp;
      @(posedge clk);
      #1;
      reset = 1'b1;
      run   = 1'b0;
      push("bsa_release_t0", mk(3'd0, 3'd0, NO));
      fetch(3'd7, 1'b0, 1'b1);
      step("hlt_t3", 1'b0, 1'b0, mk(3'd3, 3'd0, NO, 2'd0, 1'b1, 1'b1));
      step("halted_run1_a", 1'b1, 1'b0, mk(3'd0, 3'd0, NO, 2'd0, 1'b0, 1'b0, 1'b1));
      step("halted_run1_b", 1'b1, 1'b0, mk(3'd0, 3'd0, NO, 2'd0, 1'b0, 1'b0, 1'b1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      push("halt_cleared", mk(3'd0, 3'd0, NO));
      for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations pending, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
